// File: rtl/alu_writeback.sv
// ALU execute-to-writeback stage: flags, overflow trap/counter, 2-entry write FIFO.
// Write appears the cycle after accept; in_ready is registered and drops when the FIFO fills.
module alu_writeback #(
   parameter int WIDTH = 32,
   parameter int RADDR = 5,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_carryout,
   input  logic             in_overflow,
   input  logic             in_zero,
   input  logic [2:0]       in_command,
   input  logic [RADDR-1:0] in_rd,
   input  logic             trap_en,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [RADDR-1:0] wb_addr,
   output logic [WIDTH-1:0] wb_data,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             trap,
   output logic [CNTW-1:0]  ovf_count
);

   logic [RADDR-1:0] fifo_addr [2];
   logic [WIDTH-1:0] fifo_data [2];
   logic             head;
   logic             tail;
   logic [1:0]       count;
   logic [1:0]       count_next;
   logic             accept;
   logic             arith;
   logic             ovf_event;
   logic             trapped;
   logic             update;
   logic             push;
   logic             pop;

   always_comb begin
      accept     = in_valid & in_ready;
      arith      = (in_command[2:1] == 2'b00);
      ovf_event  = accept & arith & in_overflow;
      trapped    = ovf_event & trap_en;
      update     = accept & ~trapped;
      push       = update & (in_rd != '0);
      pop        = wb_valid & wb_ready;
      count_next = count + {1'b0, push} - {1'b0, pop};
   end

   assign wb_valid = (count != 2'd0);
   // Outputs are forced to zero when idle so reset and empty look identical downstream.
   assign wb_addr  = wb_valid ? fifo_addr[head] : '0;
   assign wb_data  = wb_valid ? fifo_data[head] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head     <= 1'b0;
         tail     <= 1'b0;
         count    <= 2'd0;
         in_ready <= 1'b0;
      end else begin
         if (push) tail <= ~tail;
         if (pop)  head <= ~head;
         count    <= count_next;
         in_ready <= (count_next != 2'd2);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[tail] <= in_rd;
         fifo_data[tail] <= in_result;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_z    <= 1'b0;
         flag_n    <= 1'b0;
         flag_c    <= 1'b0;
         flag_v    <= 1'b0;
         trap      <= 1'b0;
         ovf_count <= '0;
      end else begin
         trap <= trapped;
         if (update) begin
            flag_z <= in_zero;
            flag_n <= in_result[WIDTH-1];
            if (arith) begin
               flag_c <= in_carryout;
               flag_v <= in_overflow;
            end
         end
         if (ovf_event && (ovf_count != '1))
            ovf_count <= ovf_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized + directed bench for alu_writeback against a queue-based behavioural model.
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_result = '0;
   logic        in_carryout = 1'b0;
   logic        in_overflow = 1'b0;
   logic        in_zero = 1'b0;
   logic [2:0]  in_command = '0;
   logic [4:0]  in_rd = '0;
   logic        trap_en = 1'b0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flag_z, flag_n, flag_c, flag_v;
   logic        trap;
   logic [7:0]  ovf_count;

   alu_writeback dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_carryout(in_carryout), .in_overflow(in_overflow), .in_zero(in_zero),
      .in_command(in_command), .in_rd(in_rd), .trap_en(trap_en),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
      .trap(trap), .ovf_count(ovf_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of pending writes plus plain flag/counter variables.
   logic [36:0] q[$];
   logic m_rdy, m_trap, m_z, m_n, m_c, m_v;
   int   m_ovf;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         m_rdy = 0; m_trap = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_ovf = 0;
      end else begin
         logic acc, pop, arith;
         acc   = in_valid && m_rdy;
         pop   = (q.size() != 0) && wb_ready;
         arith = (in_command == 3'd0) || (in_command == 3'd1);
         m_trap = 0;
         if (pop) void'(q.pop_front());
         if (acc) begin
            if (arith && in_overflow && m_ovf < 255) m_ovf++;
            if (arith && in_overflow && trap_en) m_trap = 1;
            else begin
               m_z = in_zero;
               m_n = in_result[31];
               if (arith) begin m_c = in_carryout; m_v = in_overflow; end
               if (in_rd != 0) q.push_back({in_rd, in_result});
            end
         end
         m_rdy = (q.size() < 2);
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         chk("in_ready", in_ready, m_rdy);
         chk("wb_valid", wb_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("wb_addr", wb_addr, q[0][36:32]);
            chk("wb_data", wb_data, q[0][31:0]);
         end
         chk("flag_z", flag_z, m_z);
         chk("flag_n", flag_n, m_n);
         chk("flag_c", flag_c, m_c);
         chk("flag_v", flag_v, m_v);
         chk("trap", trap, m_trap);
         chk("ovf_count", ovf_count, m_ovf);
      end
   end

   logic [4:0] wlog[$];
   always @(posedge clk)
      if (reset_n && wb_valid && wb_ready) wlog.push_back(wb_addr);

   task automatic send(input logic [2:0] cmd, input logic [4:0] rd, input logic [31:0] res,
                       input logic c, input logic v, input logic z, input logic ten);
      int tries;
      logic acc;
      in_valid = 1; in_command = cmd; in_rd = rd; in_result = res;
      in_carryout = c; in_overflow = v; in_zero = z; trap_en = ten;
      tries = 0; acc = 0;
      while (!acc && tries < 50) begin
         acc = in_ready;
         @(posedge clk);
         @(negedge clk);
         tries++;
      end
      if (!acc) chk("send_timeout", acc, 1);
      in_valid = 0;
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
      chk("rst_ovf", ovf_count, 0);
      reset_n = 1;
      @(negedge clk);
      chk("ready_after_rst", in_ready, 1);

      // Single ADD with immediate drain
      wb_ready = 1;
      send(3'd0, 5'd3, 32'h5, 0, 0, 0, 0);
      chk("t1_valid", wb_valid, 1);
      chk("t1_addr", wb_addr, 3);
      chk("t1_data", wb_data, 5);
      chk("t1_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
      @(negedge clk);
      chk("t1_one_cycle", wb_valid, 0);

      // Fill with wb_ready low, third held off
      wb_ready = 0;
      base = wlog.size();
      send(3'd2, 5'd1, 32'h11, 0, 0, 0, 0);
      send(3'd7, 5'd2, 32'h22, 0, 0, 0, 0);
      chk("t2_full_ready", in_ready, 0);
      in_valid = 1; in_command = 3'd4; in_rd = 5'd4; in_result = 32'h44;
      repeat (3) @(negedge clk);
      chk("t2_held_off", in_ready, 0);
      wb_ready = 1;
      @(negedge clk);
      chk("t2_ready_back", in_ready, 1);
      send(3'd4, 5'd4, 32'h44, 0, 0, 0, 0);
      repeat (4) @(negedge clk);
      chk("t2_nwrites", wlog.size() - base, 3);
      if (wlog.size() - base == 3) begin
         chk("t2_order0", wlog[base], 1);
         chk("t2_order1", wlog[base+1], 2);
         chk("t2_order2", wlog[base+2], 4);
      end

      // Trapped SUB then the same SUB untrapped
      send(3'd1, 5'd6, 32'h8000_0000, 0, 1, 0, 1);
      chk("t3_trap", trap, 1);
      chk("t3_nowrite", wb_valid, 0);
      chk("t3_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
      chk("t3_ovf1", ovf_count, 1);
      @(negedge clk);
      chk("t3_trap_pulse", trap, 0);
      send(3'd1, 5'd6, 32'h8000_0000, 0, 1, 0, 0);
      chk("t3_written", wb_valid, 1);
      chk("t3_vn", {flag_n, flag_v}, 2'b11);
      chk("t3_ovf2", ovf_count, 2);

      // Carry survives a logic op to r0
      send(3'd0, 5'd5, 32'h1, 1, 0, 0, 0);
      send(3'd4, 5'd0, 32'h0, 0, 0, 1, 0);
      chk("t4_zc", {flag_z, flag_c}, 2'b11);
      chk("t4_r0_nowrite", wb_valid, 0);

      // Counter saturation
      for (int i = 0; i < 300; i++) send(3'd0, 5'd7, 32'h7fff_ffff, 0, 1, 0, 0);
      chk("t5_sat", ovf_count, 255);
      repeat (3) @(negedge clk);

      // Reset with two entries pending
      wb_ready = 0;
      send(3'd0, 5'd8, 32'h8, 0, 0, 0, 0);
      send(3'd0, 5'd9, 32'h9, 0, 0, 0, 0);
      #2 reset_n = 0;
      #1;
      chk("t6_valid", wb_valid, 0);
      chk("t6_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
      chk("t6_ovf", ovf_count, 0);
      @(negedge clk);
      reset_n = 1;
      wb_ready = 1;
      base = wlog.size();
      repeat (10) @(negedge clk);
      chk("t6_no_stale", wlog.size() - base, 0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         in_command  = 3'($urandom_range(0, 7));
         in_rd       = 5'($urandom_range(0, 3));
         in_result   = $urandom;
         in_carryout = 1'($urandom);
         in_overflow = ($urandom_range(0, 3) == 0);
         in_zero     = 1'($urandom);
         trap_en     = 1'($urandom);
         wb_ready    = ($urandom_range(0, 2) != 0);
         @(negedge clk);
      end
      in_valid = 0;
      wb_ready = 1;
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
